// File: rtl/fwd_operand_reg.sv
// N-source forwarding operand register for one ALU operand, with stall, flush and sticky capture.
// Define FWD_OPERAND_STATS_EN to add the saturating forwarded-load counter fwd_cnt_o.
//
// state | meaning
// RUN   | normal operation, output loads every unstalled cycle
// HOLD  | stalled, nothing captured yet
// CAP   | stalled, a forwarded operand is latched and will be released on unstall
module fwd_operand_reg #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 3,
   localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_SRC*WIDTH-1:0] data_i,
   input  logic [NUM_SRC-2:0]       sel_i,
   input  logic                     valid_i,
   input  logic                     stall_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     valid_o,
   output logic                     fwd_o,
   output logic [SRC_W-1:0]         src_o,
`ifdef FWD_OPERAND_STATS_EN
   output logic [31:0]              fwd_cnt_o,
`endif
   output logic                     pending_o
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_CAP  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             fwd_q, fwd_d;
   logic [SRC_W-1:0] src_q, src_d;
   logic [WIDTH-1:0] cap_data_q, cap_data_d;
   logic [SRC_W-1:0] cap_src_q, cap_src_d;

   logic [SRC_W-1:0] live_src;
   logic [WIDTH-1:0] live_data;
   logic             live_fwd;
   logic             load_en;

   // Highest set request bit wins; later iterations override earlier ones.
   always_comb begin
      live_src = '0;
      for (int j = 0; j < NUM_SRC - 1; j++) begin
         if (sel_i[j]) live_src = SRC_W'(j + 1);
      end
   end

   assign live_data = data_i[live_src*WIDTH +: WIDTH];
   assign live_fwd  = (live_src != '0);

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      valid_d    = valid_q;
      fwd_d      = fwd_q;
      src_d      = src_q;
      cap_data_d = cap_data_q;
      cap_src_d  = cap_src_q;
      load_en    = 1'b0;

      if (flush_i) begin
         data_d     = '0;
         valid_d    = 1'b0;
         fwd_d      = 1'b0;
         src_d      = '0;
         cap_data_d = '0;
         cap_src_d  = '0;
         state_d    = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN, ST_HOLD: begin
               if (!stall_i) begin
                  load_en = 1'b1;
                  data_d  = live_data;
                  src_d   = live_src;
                  fwd_d   = live_fwd;
                  valid_d = valid_i;
                  state_d = ST_RUN;
               end else if (valid_i && live_fwd) begin
                  cap_data_d = live_data;
                  cap_src_d  = live_src;
                  state_d    = ST_CAP;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            ST_CAP: begin
               // Live inputs are ignored on release; only the captured operand is presented.
               if (!stall_i) begin
                  load_en    = 1'b1;
                  data_d     = cap_data_q;
                  src_d      = cap_src_q;
                  fwd_d      = 1'b1;
                  valid_d    = 1'b1;
                  cap_data_d = '0;
                  cap_src_d  = '0;
                  state_d    = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_RUN;
         data_q     <= '0;
         valid_q    <= 1'b0;
         fwd_q      <= 1'b0;
         src_q      <= '0;
         cap_data_q <= '0;
         cap_src_q  <= '0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         fwd_q      <= fwd_d;
         src_q      <= src_d;
         cap_data_q <= cap_data_d;
         cap_src_q  <= cap_src_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign fwd_o     = fwd_q;
   assign src_o     = src_q;
   assign pending_o = (state_q == ST_CAP);

`ifdef FWD_OPERAND_STATS_EN
   logic [31:0] fwd_cnt_q, fwd_cnt_d;

   always_comb begin
      fwd_cnt_d = fwd_cnt_q;
      if (load_en && fwd_d && valid_d && (fwd_cnt_q != 32'hFFFF_FFFF))
         fwd_cnt_d = fwd_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) fwd_cnt_q <= '0;
      else       fwd_cnt_q <= fwd_cnt_d;
   end

   assign fwd_cnt_o = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_operand_reg.sv
// Directed, table-driven bench for fwd_operand_reg (WIDTH=32, NUM_SRC=3).
module tb_fwd_operand_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic [95:0] data;
   logic [1:0]  sel;
   logic        valid, stall, flush;
   logic [31:0] data_o;
   logic        valid_o, fwd_o, pending_o;
   logic [1:0]  src_o;
`ifdef FWD_OPERAND_STATS_EN
   logic [31:0] fwd_cnt_o;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fwd_operand_reg #(.WIDTH(32), .NUM_SRC(3)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .data_i    (data),
      .sel_i     (sel),
      .valid_i   (valid),
      .stall_i   (stall),
      .flush_i   (flush),
      .data_o    (data_o),
      .valid_o   (valid_o),
      .fwd_o     (fwd_o),
      .src_o     (src_o),
`ifdef FWD_OPERAND_STATS_EN
      .fwd_cnt_o (fwd_cnt_o),
`endif
      .pending_o (pending_o)
   );

   typedef struct {
      logic        rst, flush, stall, valid;
      logic [1:0]  sel;
      logic [31:0] s0, s1, s2;
      logic [31:0] e_data;
      logic        e_valid, e_fwd;
      logic [1:0]  e_src;
      logic        e_pend;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic f, logic st, logic v, logic [1:0] sl,
                               logic [31:0] a, logic [31:0] b, logic [31:0] c,
                               logic [31:0] ed, logic ev, logic ef, logic [1:0] es, logic ep);
      vec_t t;
      t.rst = r; t.flush = f; t.stall = st; t.valid = v; t.sel = sl;
      t.s0 = a; t.s1 = b; t.s2 = c;
      t.e_data = ed; t.e_valid = ev; t.e_fwd = ef; t.e_src = es; t.e_pend = ep;
      return t;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic r, logic f, logic st, logic v, logic [1:0] sl,
                        logic [31:0] a, logic [31:0] b, logic [31:0] c);
      @(negedge clk);
      rst = r; flush = f; stall = st; valid = v; sel = sl;
      data = {c, b, a};
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(string tag, logic [31:0] ed, logic ev, logic ef, logic [1:0] es, logic ep);
      chk({tag, ".data"},    data_o,           ed);
      chk({tag, ".valid"},   {31'd0, valid_o}, {31'd0, ev});
      chk({tag, ".fwd"},     {31'd0, fwd_o},   {31'd0, ef});
      chk({tag, ".src"},     {30'd0, src_o},   {30'd0, es});
      chk({tag, ".pending"}, {31'd0, pending_o}, {31'd0, ep});
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 1'b0; valid = 1'b0; sel = 2'b00; data = '0;

      //        rst  fl  st  v  sel    s0            s1            s2             data          v  f  src  pend
      tbl.push_back(mk(1, 0, 1, 1, 2'b11, 32'h9999_9999, 32'h8888_8888, 32'h7777_7777, 32'h0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 2'b01, 32'h9999_9999, 32'h8888_8888, 32'h7777_7777, 32'h0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2'b11, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h3333_3333, 1, 1, 2'd2, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2'b01, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h2222_2222, 1, 1, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2'b00, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h1111_1111, 1, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 2'b10, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h3333_3333, 0, 1, 2'd2, 0));
      // sticky capture of DEADBEEF, then producer vanishes for three stalled cycles
      tbl.push_back(mk(0, 0, 1, 1, 2'b01, 32'h1111_1111, 32'hDEAD_BEEF, 32'h3333_3333, 32'h3333_3333, 0, 1, 2'd2, 1));
      tbl.push_back(mk(0, 0, 1, 1, 2'b00, 32'h1111_1111, 32'h0,         32'h3333_3333, 32'h3333_3333, 0, 1, 2'd2, 1));
      tbl.push_back(mk(0, 0, 1, 1, 2'b00, 32'h1111_1111, 32'h0,         32'h3333_3333, 32'h3333_3333, 0, 1, 2'd2, 1));
      tbl.push_back(mk(0, 0, 1, 1, 2'b00, 32'h1111_1111, 32'h0,         32'h3333_3333, 32'h3333_3333, 0, 1, 2'd2, 1));
      tbl.push_back(mk(0, 0, 0, 1, 2'b00, 32'h1111_1111, 32'h0,         32'h3333_3333, 32'hDEAD_BEEF, 1, 1, 2'd1, 0));
      // capture then flush together with stall
      tbl.push_back(mk(0, 0, 1, 1, 2'b10, 32'h1111_1111, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF, 1, 1, 2'd1, 1));
      tbl.push_back(mk(0, 1, 1, 1, 2'b10, 32'h1111_1111, 32'h0, 32'h1234_5678, 32'h0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2'b00, 32'hCAFE_0000, 32'h0, 32'h0,         32'hCAFE_0000, 1, 0, 2'd0, 0));
      // stall without a forward goes to HOLD
      tbl.push_back(mk(0, 0, 1, 1, 2'b00, 32'h5A5A_5A5A, 32'h0, 32'h0,         32'hCAFE_0000, 1, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 2'b00, 32'h5A5A_5A5A, 32'h0, 32'h0,         32'hCAFE_0000, 1, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2'b10, 32'h5A5A_5A5A, 32'h0, 32'h0000_ABCD, 32'h0000_ABCD, 1, 1, 2'd2, 0));
      // invalid operand never captures; HOLD -> CAP; reset discards capture
      tbl.push_back(mk(0, 0, 1, 0, 2'b11, 32'h0, 32'h4444_4444, 32'h6666_6666, 32'h0000_ABCD, 1, 1, 2'd2, 0));
      tbl.push_back(mk(0, 0, 1, 1, 2'b01, 32'h0, 32'h5555_5555, 32'h6666_6666, 32'h0000_ABCD, 1, 1, 2'd2, 1));
      tbl.push_back(mk(1, 0, 1, 1, 2'b01, 32'h0, 32'h5555_5555, 32'h6666_6666, 32'h0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2'b01, 32'h0, 32'h7777_7777, 32'h0,         32'h7777_7777, 1, 1, 2'd1, 0));
      // first capture wins; release ignores live inputs and a low valid_i
      tbl.push_back(mk(0, 0, 1, 1, 2'b01, 32'h0, 32'hAAAA_AAAA, 32'h0,         32'h7777_7777, 1, 1, 2'd1, 1));
      tbl.push_back(mk(0, 0, 1, 1, 2'b11, 32'h0, 32'h0,         32'hBBBB_BBBB, 32'h7777_7777, 1, 1, 2'd1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 2'b00, 32'hCCCC_CCCC, 32'h0, 32'h0,         32'hAAAA_AAAA, 1, 1, 2'd1, 0));
      tbl.push_back(mk(0, 1, 0, 1, 2'b11, 32'h1, 32'h2, 32'h3,                 32'h0, 0, 0, 2'd0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].flush, tbl[i].stall, tbl[i].valid, tbl[i].sel,
               tbl[i].s0, tbl[i].s1, tbl[i].s2);
         check_out($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_valid,
                   tbl[i].e_fwd, tbl[i].e_src, tbl[i].e_pend);
      end

      // Release from CAP followed immediately by a new stall with no forward.
      drive(0, 0, 1, 1, 2'b10, 32'h0, 32'h0, 32'h0F0F_0F0F);
      check_out("seq_cap", 32'h0, 0, 0, 2'd0, 1);
      drive(0, 0, 0, 1, 2'b00, 32'hFFFF_0000, 32'h0, 32'h0);
      check_out("seq_rel", 32'h0F0F_0F0F, 1, 1, 2'd2, 0);
      drive(0, 0, 1, 1, 2'b00, 32'h1357_9BDF, 32'h0, 32'h0);
      check_out("seq_hold", 32'h0F0F_0F0F, 1, 1, 2'd2, 0);
      drive(0, 0, 0, 1, 2'b01, 32'h0, 32'h2468_ACE0, 32'h0);
      check_out("seq_out", 32'h2468_ACE0, 1, 1, 2'd1, 0);

`ifdef FWD_OPERAND_STATS_EN
      drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
      chk("cnt_reset", fwd_cnt_o, 32'd0);
      for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 2'(k % 2 + 1), 32'h1, 32'h2, 32'h3);
      for (int k = 0; k < 2; k++) drive(0, 0, 0, 1, 2'b00, 32'h1, 32'h2, 32'h3);
      drive(0, 1, 0, 1, 2'b11, 32'h1, 32'h2, 32'h3);
      chk("cnt_five", fwd_cnt_o, 32'd5);
      drive(0, 0, 1, 1, 2'b01, 32'h1, 32'h2, 32'h3);
      drive(0, 0, 0, 0, 2'b00, 32'h1, 32'h2, 32'h3);
      chk("cnt_cap_release", fwd_cnt_o, 32'd6);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fwd_operand_reg.md
Name: fwd_operand_reg

Overview:
- Parametrised successor to the 3-input forwarding mux in the EX stage.
- N-source priority select with a registered output stage, plus stall, flush and valid handling.
- Sticky capture: a forwarded value seen during a stall is latched, so it survives the producer leaving MEM/WB before the consumer is released.
- One instance per ALU operand, sitting between the ID/EX register and the ALU.

Parameters:
- WIDTH, 32, data width in bits.
- NUM_SRC, 3, number of sources; legal range 2..8. Source 0 is the register-file value; sources 1..NUM_SRC-1 are forwarding paths.
- SRC_W, clog2(NUM_SRC), derived localparam; width of src_o.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  NUM_SRC*WIDTH  packed sources; source k is at [k*WIDTH +: WIDTH].
- sel_i  in  NUM_SRC-1  bit j requests source j+1; the highest set bit wins; all zero selects source 0.
- valid_i  in  1  the operand on data_i/sel_i is meaningful this cycle.
- stall_i  in  1  consumer stalled; hold the output.
- flush_i  in  1  squash the stage contents.
- data_o  out  WIDTH  registered operand.
- valid_o  out  1  data_o is meaningful.
- fwd_o  out  1  data_o came from a source other than 0.
- src_o  out  SRC_W  index of the source that produced data_o.
- pending_o  out  1  a captured forwarded value is waiting; high exactly when state = CAP.

Behaviour:
- Reset: data_o=0, valid_o=0, fwd_o=0, src_o=0, pending_o=0, capture register=0, state=RUN.
- Priority of events: rst_i > flush_i > stall_i > normal load.
- Combinational select: s = index of the highest set bit of sel_i, plus 1; s=0 if sel_i is zero. live = source s.
- Latency: 1 cycle from data_i/sel_i to data_o when not stalled.
- "Load live": data_o<=live, src_o<=s, fwd_o<=(s!=0), valid_o<=valid_i.
- States: RUN, HOLD (stalled, nothing captured), CAP (stalled, value captured).
- RUN:
  - stall_i=0: load live; stay in RUN.
  - stall_i=1 & valid_i & s!=0: capture {live, s}; go to CAP.
  - stall_i=1 otherwise: go to HOLD.
  - Outputs hold whenever stall_i=1.
- HOLD:
  - stall_i=1 & valid_i & s!=0: capture; go to CAP.
  - stall_i=1 otherwise: stay in HOLD.
  - stall_i=0: load live; go to RUN.
- CAP:
  - stall_i=1: stay in CAP. The first capture wins; later sel_i/data_i are ignored.
  - stall_i=0: data_o<=captured data, src_o<=captured index, fwd_o<=1, valid_o<=1; clear the capture register; go to RUN. Live inputs are ignored in this cycle.
- flush_i=1 in any state, including together with stall_i:
  - data_o=0, valid_o=0, fwd_o=0, src_o=0.
  - Capture register cleared; go to RUN.
- rst_i mid-stall or while in CAP: full reset values; the captured value is discarded.
- Outputs do not change while stall_i=1, except on flush or reset.
- sel_i bits are ignored when valid_i=0 for capture decisions; the load still records valid_o=0.

Optional Feature:
- Macro: FWD_OPERAND_STATS_EN.
- When defined:
  - Adds output port fwd_cnt_o, 32 bits.
  - Increments by 1 on every cycle in which the output register loads with fwd=1 and valid=1. This includes release from CAP.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by rst_i; flush_i does not affect it.
- When undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan (WIDTH=32, NUM_SRC=3):
- Reset: rst_i=1 for 2 cycles with arbitrary inputs -> data_o=0, valid_o=0, fwd_o=0, src_o=0, pending_o=0.
- Priority: src0/1/2=0x11111111/0x22222222/0x33333333, valid_i=1.
  - sel_i=11 -> next cycle data_o=0x33333333, src_o=2, fwd_o=1.
  - sel_i=01 -> 0x22222222, src_o=1.
  - sel_i=00 -> 0x11111111, fwd_o=0.
- Sticky capture: stall_i=1, sel_i=01, src1=0xDEADBEEF; then src1=0, sel_i=00, stall held 3 more cycles -> outputs frozen, pending_o=1. Drop stall_i -> next cycle data_o=0xDEADBEEF, src_o=1, fwd_o=1, pending_o=0.
- Flush beats stall: in CAP, flush_i=1 with stall_i=1 -> data_o=0, valid_o=0, pending_o=0. Next cycle stall_i=0, sel_i=00, src0=0xCAFE0000 -> data_o=0xCAFE0000, fwd_o=0.
- Stall with no forward: stall_i=1, sel_i=00 for 2 cycles -> pending_o=0. Release with sel_i=10, src2=0x0000ABCD -> data_o=0x0000ABCD, src_o=2.
- Stats (macro defined): 5 forwarded valid loads, 2 unforwarded loads, 1 flush -> fwd_cnt_o=5. Counter preset to 0xFFFFFFFF plus one more forwarded load -> stays 0xFFFFFFFF.
